ahb_dphase_resp_mux: RTL
========================

# ahb_dphase_resp_mux

Parametrised AHB response multiplexer: next generation of the one-hot slave-to-master mux. Latches the decoder's one-hot select in the address phase and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master in the data phase. Transfers with a zero or multi-hot select go to a built-in default slave, which returns the two-cycle ERROR response and increments a saturating error counter. The block sits between the slave-side response buses and one master port of the generated interconnect.

## Interface
- CHANNEL_NUM, 4, number of slave channels (≥1)
- DATA_WIDTH, 32, HRDATA width
- ERR_CNT_WIDTH, 8, width of the default-slave error counter
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  reset, synchronous, active-high
- htrans  in  2  master HTRANS for the current address phase (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- sel_addr  in  CHANNEL_NUM  address-phase one-hot slave select from the decoder
- hready_in  in  CHANNEL_NUM  per-slave HREADYOUT
- hresp_in  in  CHANNEL_NUM  per-slave HRESP (1 = ERROR)
- hrdata_in  in  [CHANNEL_NUM-1:0][DATA_WIDTH-1:0]  per-slave HRDATA
- HRDATA  out  DATA_WIDTH  routed read data
- HREADY  out  1  routed ready, fed back to the master and all slaves
- HRESP  out  1  routed response
- dphase_sel  out  CHANNEL_NUM  registered data-phase one-hot select; all zero when not in SLAVE
- err_cnt  out  ERR_CNT_WIDTH  number of default-slave ERROR responses, saturating

## Operation
- FSM states: IDLE, SLAVE, ERR1, ERR2. Register dsel[CHANNEL_NUM-1:0].
- Address sampling occurs only on a rising edge where HREADY==1 (output value in that cycle). This applies in IDLE, SLAVE and ERR2.
- Sampling rule:
  - htrans[1]==0 (IDLE/BUSY) -> IDLE, dsel=0.
  - htrans[1]==1 and sel_addr exactly one-hot -> SLAVE, dsel=sel_addr.
  - htrans[1]==1 and sel_addr zero or multi-hot -> ERR1, dsel=0, err_cnt increments (held at all-ones once saturated).
- HREADY==0 in SLAVE means the slave is stalling: hold state and dsel, and ignore htrans and sel_addr.
- ERR1 -> ERR2 unconditionally on the next edge.
- Outputs (combinational from state and inputs):
  - IDLE: HRDATA=0, HREADY=1, HRESP=0.
  - SLAVE, channel i = index of dsel: HRDATA=hrdata_in[i], HREADY=hready_in[i], HRESP=hresp_in[i].
  - ERR1: HRDATA=0, HREADY=0, HRESP=1.
  - ERR2: HRDATA=0, HREADY=1, HRESP=1.
- dphase_sel = dsel in SLAVE, else 0.
- Slave ERROR responses (hresp_in) pass through unchanged and do not increment err_cnt.
- Reset (HRESET high at an edge): state=IDLE, dsel=0, err_cnt=0. This overrides any in-flight transfer, including a stalled SLAVE phase or ERR1.
- Outputs after reset: HRDATA=0, HREADY=1, HRESP=0, dphase_sel=0, err_cnt=0.

## Timing
- Address phase accepted at edge N routes data-phase response in cycle N+1.
- Latency from hrdata_in, hready_in and hresp_in to the outputs is zero cycles (combinational). No output register.
- Pipelined back-to-back transfers: the new select is captured on the same edge that completes the previous data phase (HREADY==1), so there are no bubble cycles.
- The default-slave error takes exactly 2 data-phase cycles. The next address phase is sampled at the end of ERR2.
- err_cnt updates on the edge that enters ERR1 and is visible in the ERR1 cycle.
- CHANNEL_NUM=1 is legal: a valid transfer with sel_addr=1 goes to SLAVE, and sel_addr=0 goes to ERR1.

## Test plan
- Reset: hold HRESET for 2 cycles with random inputs -> HREADY=1, HRESP=0, HRDATA=0, dphase_sel=0, err_cnt=0.
- Back-to-back NONSEQ with sel_addr=0001 then 0100, all slaves ready, hrdata_in[0]=0xAAAA0000, hrdata_in[2]=0x5555FFFF -> HRDATA=0xAAAA0000 in cycle N+1 and 0x5555FFFF in cycle N+2. dphase_sel follows 0001 then 0100.
- Wait states: slave 1 selected, hready_in[1] low for 3 cycles, sel_addr changes to 1000 meanwhile -> HREADY=0 for 3 cycles, dphase_sel stays 0010, and the change is captured only when hready_in[1] rises.
- Illegal select: NONSEQ with sel_addr=0000, then NONSEQ with 0011 -> two ERR1/ERR2 pairs (HREADY 0,1 with HRESP=1 in both cycles), err_cnt = 1 then 2. A following IDLE transfer gives HREADY=1, HRESP=0.
- Saturation and pass-through: ERR_CNT_WIDTH=2, five illegal transfers -> err_cnt stays at 3. A slave with hresp_in=1 passes HRESP=1 through without incrementing err_cnt.
- Reset mid-ERR1 -> IDLE outputs on the next cycle, and err_cnt=0.

Source files
------------

// File: rtl/ahb_dphase_resp_mux.sv
// AHB data-phase response multiplexer: latches the decoder's one-hot select in
// the address phase and routes the chosen slave's response back to the master.
module ahb_dphase_resp_mux #(
  parameter int CHANNEL_NUM   = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                   HCLK,
  input  logic                                   HRESET,
  input  logic [1:0]                             htrans,
  input  logic [CHANNEL_NUM-1:0]                 sel_addr,
  input  logic [CHANNEL_NUM-1:0]                 hready_in,
  input  logic [CHANNEL_NUM-1:0]                 hresp_in,
  input  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] hrdata_in,
  output logic [DATA_WIDTH-1:0]                  HRDATA,
  output logic                                   HREADY,
  output logic                                   HRESP,
  output logic [CHANNEL_NUM-1:0]                 dphase_sel,
  output logic [ERR_CNT_WIDTH-1:0]               err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SLAVE = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  logic [1:0]             state;
  logic [CHANNEL_NUM-1:0] dsel;
  logic                   sel_seen;
  logic                   sel_multi;
  logic                   sel_onehot;
  logic [DATA_WIDTH-1:0]  slave_rdata;
  logic                   slave_ready;
  logic                   slave_resp;

  // Zero and multi-hot selects both fall through to the default slave.
  always_comb begin
    sel_seen  = 1'b0;
    sel_multi = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_addr[i]) begin
        if (sel_seen) sel_multi = 1'b1;
        sel_seen = 1'b1;
      end
    end
    sel_onehot = sel_seen & ~sel_multi;
  end

  // dsel is one-hot whenever it is non-zero, so an AND-OR mux is exact.
  always_comb begin
    slave_rdata = '0;
    slave_ready = 1'b0;
    slave_resp  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (dsel[i]) begin
        slave_rdata = slave_rdata | hrdata_in[i];
        slave_ready = slave_ready | hready_in[i];
        slave_resp  = slave_resp  | hresp_in[i];
      end
    end
  end

  always_comb begin
    HRDATA     = '0;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    dphase_sel = '0;
    case (state)
      ST_SLAVE: begin
        HRDATA     = slave_rdata;
        HREADY     = slave_ready;
        HRESP      = slave_resp;
        dphase_sel = dsel;
      end
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: ;
    endcase
  end

  // The next address phase is captured on the edge that completes the current
  // data phase, so back-to-back transfers run without bubbles.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      dsel    <= '0;
      err_cnt <= '0;
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
    end else if (HREADY) begin
      if (!htrans[1]) begin
        state <= ST_IDLE;
        dsel  <= '0;
      end else if (sel_onehot) begin
        state <= ST_SLAVE;
        dsel  <= sel_addr;
      end else begin
        state <= ST_ERR1;
        dsel  <= '0;
        if (!(&err_cnt)) err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

endmodule
